rf_access_ctrl: RTL and testbench

Sequences all access to the 32-entry register file in the RV32I pipeline CPU. After reset it clears every register. It then arbitrates the single write port between pipeline writeback and a debug/trace port, and serves debug reads through a dedicated read port. It sits between the writeback stage, the debug bridge and the register file's write/read ports.

---
 rtl/rf_access_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_rf_access_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_access_ctrl.sv
// Register-file access sequencer: post-reset clear, write-port arbitration, debug reads.
// Latency: writes and grants are combinational (same cycle); debug read data returns one cycle after grant.
// Backpressure: a blocked debug write waits for dbg_gnt; after STARVE_LIMIT blocked cycles stall_req holds off writeback.
//
// Optional feature macro: RF_CLEAR_EN
//   defined   - after reset every register is written with zero (CLEAR), rf_busy high meanwhile
//   undefined - comes out of reset straight into RUN; rf_busy and wb_drop are tied low
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   wb_wen/waddr/wdata      writeback write request (highest write priority)
//   dbg_req/we/addr/wdata   debug request; dbg_gnt accepts it this cycle
//   dbg_rvalid/dbg_rdata    registered debug read response (one-cycle pulse)
//   rf_wen/waddr/wdata      register file write port
//   rf_raddr/rf_rdata       register file debug read port (combinational read)
//   rf_busy                 pipeline must hold while the clear runs
//   stall_req               pipeline must not assert wb_wen next cycle
//   wb_drop                 sticky flag: a writeback arrived during the clear and was lost
module rf_access_ctrl #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REGS     = 2**ADDR_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wb_wen,
  input  logic [ADDR_WIDTH-1:0] wb_waddr,
  input  logic [DATA_WIDTH-1:0] wb_wdata,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [ADDR_WIDTH-1:0] rf_raddr,
  input  logic [DATA_WIDTH-1:0] rf_rdata,
  output logic                  rf_busy,
  output logic                  stall_req,
  output logic                  wb_drop
);

  localparam int                    CNT_W    = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0]      CNT_TOP  = CNT_W'(STARVE_LIMIT - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

`ifdef RF_CLEAR_EN
  localparam state_t RESET_STATE = ST_CLEAR;
`else
  localparam state_t RESET_STATE = ST_RUN;
`endif

  state_t                  state;
  state_t                  next_state;
  logic [ADDR_WIDTH-1:0]   clr_idx;
  logic [CNT_W-1:0]        starve_cnt;
  logic                    in_run;
  logic                    wb_hit;
  logic                    dbg_wr;
  logic                    dbg_rd;
  logic                    blocked;
  logic [DATA_WIDTH-1:0]   rd_value;

  assign in_run = (state == ST_RUN);
  // Writeback to x0 is a no-op and must not steal the port from a debug write.
  assign wb_hit = wb_wen && (wb_waddr != '0);
  assign dbg_wr = dbg_req && dbg_we;
  assign dbg_rd = dbg_req && !dbg_we;

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= RESET_STATE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    next_state = state;
    case (state)
      ST_CLEAR: if (clr_idx == LAST_IDX) next_state = ST_RUN;
      ST_RUN:   next_state = ST_RUN;
      default:  next_state = RESET_STATE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    rf_wen   = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    dbg_gnt  = 1'b0;
    case (state)
      ST_CLEAR: begin
        rf_wen   = 1'b1;
        rf_waddr = clr_idx;
        rf_wdata = '0;
      end
      ST_RUN: begin
        if (wb_hit) begin
          rf_wen   = 1'b1;
          rf_waddr = wb_waddr;
          rf_wdata = wb_wdata;
        end else if (dbg_wr) begin
          // A debug write to x0 is accepted but never reaches the array.
          dbg_gnt  = 1'b1;
          rf_wen   = (dbg_addr != '0);
          rf_waddr = dbg_addr;
          rf_wdata = dbg_wdata;
        end
        if (dbg_rd) dbg_gnt = 1'b1;
      end
      default: ;
    endcase
  end

  assign rf_raddr = dbg_addr;

`ifdef RF_CLEAR_EN
  assign rf_busy = (state == ST_CLEAR);
`else
  assign rf_busy = 1'b0;
`endif

  // ---------------------------------------------------------------- clear index
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clr_idx <= '0;
    end else if (state == ST_CLEAR) begin
      clr_idx <= clr_idx + 1'b1;
    end
  end

  // ---------------------------------------------------------------- dropped writeback flag
`ifdef RF_CLEAR_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_drop <= 1'b0;
    end else if ((state == ST_CLEAR) && wb_wen) begin
      wb_drop <= 1'b1;
    end
  end
`else
  assign wb_drop = 1'b0;
`endif

  // ---------------------------------------------------------------- debug read response
  // Write-first: a same-cycle write to the read address is forwarded, since the
  // array only updates at the clock edge that also captures the read data.
  assign rd_value = (dbg_addr == '0)                     ? '0       :
                    (rf_wen && (rf_waddr == dbg_addr))   ? rf_wdata :
                                                           rf_rdata;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= '0;
    end else begin
      dbg_rvalid <= in_run && dbg_rd;
      if (in_run && dbg_rd) dbg_rdata <= rd_value;
    end
  end

  // ---------------------------------------------------------------- starvation guard
  // stall_req fires during the STARVE_LIMIT-th consecutive blocked cycle so the
  // pipeline drops wb_wen on the following cycle and the debug write gets through.
  assign blocked   = in_run && dbg_wr && wb_hit;
  assign stall_req = blocked && (starve_cnt == CNT_TOP);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!blocked || stall_req) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Directed bench for rf_access_ctrl with a small behavioural register array on the rf ports.
module tb_rf_access_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_wen;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        dbg_req;
  logic        dbg_we;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        rf_busy;
  logic        stall_req;
  logic        wb_drop;

  int checks   = 0;
  int failures = 0;

  rf_access_ctrl #(
    .ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_REGS(32), .STARVE_LIMIT(4)
  ) dut (
    .clock(clock), .reset(reset),
    .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rf_busy(rf_busy), .stall_req(stall_req), .wb_drop(wb_drop)
  );

  always #5 clock = ~clock;

  // Register array model; seeded with a recognisable pattern so stale reads stand out.
  logic [31:0] mem [32];
  bit          seeded;
  always @(posedge clock) begin
    if (!seeded) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0BAD0000 + i;
      seeded <= 1'b1;
    end else if (rf_wen) begin
      mem[rf_waddr] <= rf_wdata;
    end
  end
  assign rf_rdata = mem[rf_raddr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    wb_wen = 1'b0; wb_waddr = '0; wb_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  task automatic do_read(input logic [4:0] addr, input logic [31:0] exp, input string tag);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = addr;
    #1;
    chk({tag, "_gnt"}, dbg_gnt, 1'b1);
    chk({tag, "_raddr"}, rf_raddr, addr);
    tick();
    dbg_req = 1'b0;
    #1;
    chk({tag, "_rvalid"}, dbg_rvalid, 1'b1);
    chk({tag, "_rdata"}, dbg_rdata, exp);
    tick();
    #1;
    chk({tag, "_rvalid_pulse"}, dbg_rvalid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    idle_inputs();
    repeat (3) tick();
    #1;
    chk("rst_rvalid", dbg_rvalid, 1'b0);
    chk("rst_rdata", dbg_rdata, 32'h0);
    chk("rst_stall", stall_req, 1'b0);
    chk("rst_wb_drop", wb_drop, 1'b0);
`ifdef RF_CLEAR_EN
    chk("rst_busy", rf_busy, 1'b1);
`else
    chk("rst_busy", rf_busy, 1'b0);
`endif
    tick();
    reset = 1'b1;

`ifdef RF_CLEAR_EN
    // Clear walks x0..x31 with zero; a writeback at index 3 is dropped.
    for (int i = 0; i < 32; i++) begin
      wb_wen = (i == 3); wb_waddr = 5'd12; wb_wdata = 32'hCAFE0000;
      #1;
      chk($sformatf("clr_busy_%0d", i), rf_busy, 1'b1);
      chk($sformatf("clr_wen_%0d", i), rf_wen, 1'b1);
      chk($sformatf("clr_waddr_%0d", i), rf_waddr, i);
      chk($sformatf("clr_wdata_%0d", i), rf_wdata, 32'h0);
      chk($sformatf("clr_gnt_%0d", i), dbg_gnt, 1'b0);
      tick();
    end
    wb_wen = 1'b0;
    #1;
    chk("clr_done_busy", rf_busy, 1'b0);
    chk("clr_wb_drop", wb_drop, 1'b1);
    do_read(5'd12, 32'h0, "clr_rd12");
`else
    // No clear: debug read is served in the first cycle, writeback goes straight through.
    wb_wen = 1'b1; wb_waddr = 5'd2; wb_wdata = 32'h00000022;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd4;
    #1;
    chk("first_gnt", dbg_gnt, 1'b1);
    chk("first_wen", rf_wen, 1'b1);
    chk("first_busy", rf_busy, 1'b0);
    tick();
    idle_inputs();
    #1;
    chk("first_rvalid", dbg_rvalid, 1'b1);
    chk("first_rdata", dbg_rdata, 32'h0BAD0004);
    chk("first_wb_drop", wb_drop, 1'b0);
    tick();
`endif

    // Writeback beats a pending debug write, which goes through next cycle.
    wb_wen = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'hDEADBEEF;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd6; dbg_wdata = 32'h12345678;
    #1;
    chk("prio_c0_wen", rf_wen, 1'b1);
    chk("prio_c0_waddr", rf_waddr, 5'd5);
    chk("prio_c0_wdata", rf_wdata, 32'hDEADBEEF);
    chk("prio_c0_gnt", dbg_gnt, 1'b0);
    tick();
    wb_wen = 1'b0;
    #1;
    chk("prio_c1_gnt", dbg_gnt, 1'b1);
    chk("prio_c1_waddr", rf_waddr, 5'd6);
    chk("prio_c1_wdata", rf_wdata, 32'h12345678);
    tick();
    idle_inputs();
    do_read(5'd5, 32'hDEADBEEF, "rd_x5");
    do_read(5'd6, 32'h12345678, "rd_x6");

    // Same-cycle writeback to the read address is forwarded.
    wb_wen = 1'b1; wb_waddr = 5'd7; wb_wdata = 32'hA5A5A5A5;
    do_read(5'd7, 32'hA5A5A5A5, "byp_x7");
    wb_wen = 1'b0;

    // Starvation: 4 blocked cycles, stall_req during the 4th, grant on the 5th.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'h00000099;
    wb_wen = 1'b1; wb_wdata = 32'h11110000;
    for (int i = 1; i <= 4; i++) begin
      wb_waddr = 5'(9 + i);
      #1;
      chk($sformatf("starve_stall_%0d", i), stall_req, (i == 4));
      chk($sformatf("starve_gnt_%0d", i), dbg_gnt, 1'b0);
      tick();
    end
    wb_wen = 1'b0;
    #1;
    chk("starve_grant", dbg_gnt, 1'b1);
    chk("starve_grant_addr", rf_waddr, 5'd9);
    chk("starve_grant_stall", stall_req, 1'b0);
    tick();
    idle_inputs();
    do_read(5'd9, 32'h00000099, "rd_x9");

    // Counter restarts after a grant: 2 blocked, grant, then 3 blocked without a stall.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd14; dbg_wdata = 32'h0000000E;
    wb_wen = 1'b1; wb_waddr = 5'd15; wb_wdata = 32'h0F;
    repeat (2) tick();
    wb_wen = 1'b0;
    #1;
    chk("restart_gnt", dbg_gnt, 1'b1);
    tick();
    dbg_addr = 5'd16; dbg_wdata = 32'h10; wb_wen = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      #1;
      chk($sformatf("restart_stall_%0d", i), stall_req, 1'b0);
      tick();
    end
    wb_wen = 1'b0;
    tick();
    idle_inputs();

    // Debug write to x0 is granted but discarded; x0 reads as zero.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd0; dbg_wdata = 32'hFFFFFFFF;
    #1;
    chk("x0_gnt", dbg_gnt, 1'b1);
    chk("x0_wen", rf_wen, 1'b0);
    tick();
    idle_inputs();
    do_read(5'd0, 32'h0, "rd_x0");

    // Writeback to x0 does not block a debug write.
    wb_wen = 1'b1; wb_waddr = 5'd0; wb_wdata = 32'h77;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd3; dbg_wdata = 32'h33;
    #1;
    chk("wbx0_gnt", dbg_gnt, 1'b1);
    chk("wbx0_waddr", rf_waddr, 5'd3);
    chk("wbx0_wdata", rf_wdata, 32'h33);
    tick();
    idle_inputs();
    do_read(5'd3, 32'h33, "rd_x3");

    // Reset aborts a read response in flight.
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd5;
    tick();
    idle_inputs();
    #1;
    chk("abort_rvalid_pre", dbg_rvalid, 1'b1);
    reset = 1'b0;
    #1;
    chk("abort_rvalid", dbg_rvalid, 1'b0);
    chk("abort_rdata", dbg_rdata, 32'h0);
    tick();
    reset = 1'b1;

`ifdef RF_CLEAR_EN
    // Writeback mid-clear sets wb_drop; reset clears it and restarts at index 0.
    repeat (5) tick();
    wb_wen = 1'b1; wb_waddr = 5'd8;
    tick();
    wb_wen = 1'b0;
    #1;
    chk("midclr_wb_drop", wb_drop, 1'b1);
    chk("midclr_waddr", rf_waddr, 5'd6);
    reset = 1'b0;
    #1;
    chk("midclr_rst_drop", wb_drop, 1'b0);
    chk("midclr_rst_busy", rf_busy, 1'b1);
    tick();
    reset = 1'b1;
    #1;
    chk("midclr_restart_idx", rf_waddr, 5'd0);
`else
    #1;
    chk("norst_busy", rf_busy, 1'b0);
    do_read(5'd5, 32'hDEADBEEF, "post_rst_x5");
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
